// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor, one slice per stage
// Optional signed saturation is compiled in with CLA_PIPE_SAT_EN.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  // Returns {carry out, carry into slice MSB, slice sum}.
  function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b,
                                              input logic c0);
    logic [SW:0] c;
    logic [3:0]  p;
    logic [3:0]  g;
    logic        gc;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < NG; i++) begin
      p  = a[4*i +: 4] ^ b[4*i +: 4];
      g  = a[4*i +: 4] & b[4*i +: 4];
      gc = c[4*i];
      c[4*i+1] = g[0] | (p[0] & gc);
      c[4*i+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc);
      c[4*i+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & gc);
      c[4*i+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | ((&p) & gc);
    end
    return {c[SW], c[SW-1], a ^ b ^ c[SW-1:0]};
  endfunction

  // Operand words rotate right by one slice per stage; finished sum slices enter
  // at the top, so after the last stage the word holds the aligned sum.
  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic             c_r   [STAGES];
  logic             v_r   [STAGES];
  logic             sub_r [STAGES];
  logic             sat_r [STAGES];
  logic             ovf_r;
  logic             zero_r;

  logic [WIDTH-1:0]    st_a   [STAGES];
  logic [WIDTH-1:0]    st_b   [STAGES];
  logic                st_c   [STAGES];
  logic                st_v   [STAGES];
  logic                st_sub [STAGES];
  logic                st_sat [STAGES];
  logic [WIDTH-1:0]    nxt_a  [STAGES];
  logic [WIDTH-1:0]    nxt_b  [STAGES];
  logic                nxt_c  [STAGES];
  logic                c_msb  [STAGES];
  logic [SW+1:0]       slice_res;
  logic [WIDTH+SW-1:0] cat_a;
  logic [WIDTH+SW-1:0] cat_b;
  logic [WIDTH-1:0]    fin_sum;
  logic                fin_ovf;
  logic                stall;

  assign stall     = v_r[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_r[STAGES-1];
  assign sum       = a_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovf       = ovf_r;
  assign zero      = zero_r;

  always_comb begin
    slice_res = '0;
    cat_a     = '0;
    cat_b     = '0;
    st_a[0]   = in_a;
    st_b[0]   = in_b;
    st_c[0]   = cin | sub;
    st_v[0]   = in_valid;
    st_sub[0] = sub;
    st_sat[0] = sat;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]   = a_r[k-1];
      st_b[k]   = b_r[k-1];
      st_c[k]   = c_r[k-1];
      st_v[k]   = v_r[k-1];
      st_sub[k] = sub_r[k-1];
      st_sat[k] = sat_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_res = cla_slice(st_a[k][SW-1:0], st_b[k][SW-1:0] ^ {SW{st_sub[k]}}, st_c[k]);
      cat_a     = {slice_res[SW-1:0], st_a[k]};
      cat_b     = {st_b[k][SW-1:0], st_b[k]};
      nxt_a[k]  = cat_a[WIDTH+SW-1:SW];
      nxt_b[k]  = cat_b[WIDTH+SW-1:SW];
      nxt_c[k]  = slice_res[SW+1];
      c_msb[k]  = slice_res[SW];
    end
    fin_ovf = c_msb[STAGES-1] ^ nxt_c[STAGES-1];
    fin_sum = nxt_a[STAGES-1];
`ifdef CLA_PIPE_SAT_EN
    // A wrapped negative MSB means the true result was positive.
    if (st_sat[STAGES-1] && fin_ovf)
      fin_sum = nxt_a[STAGES-1][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        c_r[k]   <= 1'b0;
        v_r[k]   <= 1'b0;
        sub_r[k] <= 1'b0;
        sat_r[k] <= 1'b0;
      end
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= st_v[k];
        if (st_v[k]) begin
          a_r[k]   <= (k == STAGES - 1) ? fin_sum : nxt_a[k];
          b_r[k]   <= nxt_b[k];
          c_r[k]   <= nxt_c[k];
          sub_r[k] <= st_sub[k];
          sat_r[k] <= st_sat[k];
        end
      end
      if (st_v[STAGES-1]) begin
        ovf_r  <= fin_ovf;
        zero_r <= (fin_sum == '0);
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder (default and CLA_PIPE_SAT_EN builds)
module tb_cla_pipe_adder;
  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, cin = 1'b0, sub = 1'b0, sat = 1'b0, out_ready = 1'b1;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;

  logic        u2_in_valid = 1'b0, u2_cin = 1'b0, u2_sub = 1'b0, u2_sat = 1'b0, u2_out_ready = 1'b1;
  logic [31:0] u2_in_a = '0, u2_in_b = '0;
  logic        u2_in_ready, u2_out_valid, u2_cout, u2_ovf, u2_zero;
  logic [31:0] u2_sum;

  int errors = 0;
  int checks = 0;
  logic [34:0] q[$];

  cla_pipe_adder #(.WIDTH(32), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .cin(cin), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  cla_pipe_adder #(.WIDTH(32), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(u2_in_valid), .in_ready(u2_in_ready), .in_a(u2_in_a),
    .in_b(u2_in_b), .cin(u2_cin), .sub(u2_sub), .sat(u2_sat), .out_valid(u2_out_valid),
    .out_ready(u2_out_ready), .sum(u2_sum), .cout(u2_cout), .ovf(u2_ovf), .zero(u2_zero));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed/unsigned arithmetic on wide integers. Returns {ovf, zero, cout, sum}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic su, input logic sa);
    longint      ta, tb, tr;
    logic [32:0] u;
    logic [31:0] s;
    logic        o, co;
    ta = longint'($signed(a));
    tb = longint'($signed(b));
    tr = su ? (ta - tb) : (ta + tb + longint'(ci));
    o  = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
    u  = {1'b0, a} + {1'b0, b} + 33'(ci);
    co = su ? (a >= b) : u[32];
    s  = tr[31:0];
`ifdef CLA_PIPE_SAT_EN
    if (sa && o) s = (tr > 0) ? 32'h7fff_ffff : 32'h8000_0000;
`else
    if (sa && o) s = tr[31:0];
`endif
    return {o, (s == 32'h0), co, s};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] r_sum;
  logic        r_cout, r_ovf, r_zero;

  task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic su, input logic sa, input string tag);
    logic [34:0] e;
    int n;
    e = model(a, b, ci, su, sa);
    @(negedge clk);
    in_a = a; in_b = b; cin = ci; sub = su; sat = sa; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(STAGES - 1));
    chk({tag, " sum"}, 64'(sum), 64'(e[31:0]));
    chk({tag, " cout"}, 64'(cout), 64'(e[32]));
    chk({tag, " zero"}, 64'(zero), 64'(e[33]));
    chk({tag, " ovf"}, 64'(ovf), 64'(e[34]));
    r_sum = sum; r_cout = cout; r_ovf = ovf; r_zero = zero;
  endtask

  initial begin
    int n, acc, cyc;
    logic prev_stall;
    logic [34:0] e;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset sum", 64'(sum), 64'd0);
    chk("reset flags", 64'({cout, ovf, zero}), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed boundary cases
    run1(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, "ff+1");
    chk("ff+1 const sum", 64'(r_sum), 64'h0);
    chk("ff+1 const flags", 64'({r_cout, r_zero, r_ovf}), 64'b110);
    run1(32'd5, 32'd7, 1'b1, 1'b1, 1'b0, "5-7");
    chk("5-7 const sum", 64'(r_sum), 64'hFFFF_FFFE);
    chk("5-7 const cout/ovf", 64'({r_cout, r_ovf}), 64'b00);
    run1(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, "min-1");
    chk("min-1 const sum", 64'(r_sum), 64'h7FFF_FFFF);
    chk("min-1 const cout/ovf", 64'({r_cout, r_ovf}), 64'b11);
    run1(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, "max+1 sat");
`ifdef CLA_PIPE_SAT_EN
    chk("max+1 sat const sum", 64'(r_sum), 64'h7FFF_FFFF);
`else
    chk("max+1 sat const sum", 64'(r_sum), 64'h8000_0000);
`endif
    chk("max+1 sat const ovf/zero", 64'({r_ovf, r_zero}), 64'b10);
    run1(32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, "slice carry");
    chk("slice carry const", 64'({r_cout, r_sum}), 64'h0_0001_0000);

    // STAGES=2 instance, carry across its slice boundary
    @(negedge clk);
    u2_in_a = 32'h0000_FFFF; u2_in_b = 32'd1; u2_in_valid = 1'b1;
    @(posedge clk); #1;
    u2_in_valid = 1'b0;
    n = 0;
    while (!u2_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s2 latency", 64'(n), 64'd1);
    chk("s2 sum", 64'(u2_sum), 64'h0001_0000);
    chk("s2 cout", 64'(u2_cout), 64'd0);

    // Reset discards in-flight transactions
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = 32'(100 + i); in_b = 32'(i); cin = 1'b0; sub = 1'b0; sat = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("pre-reset out_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    chk("mid reset outputs", 64'({sum, cout, ovf, zero}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no stale result", 64'(out_valid), 64'd0);
    end
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    run1(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, "post-reset 1+1");
    chk("post-reset const sum", 64'(r_sum), 64'd2);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drained", 64'(out_valid), 64'd0);

    // Random back-to-back traffic with random backpressure
    acc = 0; cyc = 0; prev_stall = 1'b0;
    while ((acc < 200 || q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      if (acc < 200 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_a = $urandom; in_b = $urandom;
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (acc >= 200) ? 1'b1 : ($urandom_range(0, 9) < 7);
      #1;
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall) chk("held out_valid", 64'(out_valid), 64'd1);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("extra result", 64'(out_valid), 64'd0);
        end else begin
          e = q[0];
          chk("rand result", 64'({ovf, zero, cout, sum}), 64'(e));
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, cin, sub, sat));
        acc++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("all accepted", 64'(acc), 64'd200);
    chk("queue empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
